apb_fetch_master: RTL and testbench
===================================

Name: apb_fetch_master

Overview:
Parametrised APB3 instruction-fetch master that replaces the fixed 16-bit, one-word-at-a-time IR fetch FSM. It prefetches sequential words into a DEPTH-entry show-ahead buffer and presents them to the CPU control logic over a valid/ready interface. It also adds PC redirect with flush, PSLVERR handling and a wait-state timeout. It sits between the CPU datapath/control and the APB instruction memory.

Parameters:
ADDR_W, 16, APB address and PC width; word-addressed, PC increments by 1.
DATA_W, 16, instruction/APB data width.
DEPTH, 4, prefetch buffer entries; power of two, at least 2.
TIMEOUT, 15, maximum ACCESS cycles with pready low before abort; at least 1.
RESET_PC, 0, fetch address after reset.

Ports:
clk  input  1  clock; all logic on the rising edge.
reset  input  1  synchronous, active-low reset.
redirect_valid  input  1  one-cycle request to flush and restart fetch.
redirect_pc  input  ADDR_W  new fetch address.
instr_valid  output  1  head of buffer valid.
instr_data  output  DATA_W  head instruction.
instr_pc  output  ADDR_W  address of head instruction.
instr_ready  input  1  consumer pops the head when instr_valid is also high.
fetch_err  output  1  one-cycle pulse on slave error or timeout.
halted  output  1  high while in HALT.
paddr  output  ADDR_W  APB address.
psel  output  1  APB select.
penable  output  1  APB enable.
pwrite  output  1  tied 0; read-only master.
pwdata  output  DATA_W  tied 0.
prdata  input  DATA_W  APB read data.
pready  input  1  APB ready.
pslverr  input  1  APB slave error; sampled only when pready is high.

Behaviour:
- Reset (reset==0 at a clk edge) applies regardless of state, including mid-transfer:
  - psel, penable, pwrite, pwdata, fetch_err, halted = 0; paddr = RESET_PC.
  - Buffer count = 0, so instr_valid = 0.
  - fetch_pc = RESET_PC; state = IDLE; timeout counter = 0; discard = 0.
- States: IDLE, SETUP, ACCESS, HALT.
- IDLE: psel=0. Go to SETUP when count < DEPTH.
- SETUP: psel=1, penable=0, paddr=fetch_pc. Always go to ACCESS next cycle.
- ACCESS: psel=1, penable=1. The counter increments each cycle pready is low.
  - pready=1, pslverr=0, discard=0: push {fetch_pc, prdata}; fetch_pc increments (wraps 2^ADDR_W-1 to 0).
    - Next state is SETUP (psel stays high, back-to-back) if count_after_push < DEPTH, else IDLE.
  - pready=1, pslverr=1: no push; fetch_err=1 for one cycle; psel/penable drop; go to HALT.
  - Counter reaches TIMEOUT with pready still low: fetch_err pulse; psel/penable drop; go to HALT; counter clears.
- HALT: psel=0. The buffer still drains to the consumer. Only redirect_valid leaves HALT (to IDLE).
- Zero-wait latency: SETUP in cycle n, ACCESS in n+1, instr_valid=1 in n+2. Peak throughput is 1 word per 2 cycles.
- Buffer is show-ahead: instr_valid = (count != 0); instr_data/instr_pc come from the head entry.
- Push and pop in the same cycle: count unchanged; legal when full only because the issue check prevents a push into a full buffer.
- Redirect, any state:
  - Buffer flushes to count=0 and fetch_pc = redirect_pc; halted clears.
  - Redirect wins over a push or pop in the same cycle.
  - If in ACCESS, the APB transfer is not aborted. discard is set, the transfer completes per protocol, and its data/error/timeout is dropped with no fetch_err. The next SETUP uses redirect_pc.
  - If in SETUP, ACCESS still follows with discard set.
  - In IDLE or HALT, go to IDLE.
- paddr, psel and penable are registered outputs. paddr is stable from SETUP through the end of ACCESS.

Test Plan:
1. Zero-wait slave (mem[i]=i+0x100), reset released, instr_ready=1 -> paddr 0,1,2,... with psel continuous; consumer sees 0x100@pc0, 0x101@pc1 in order; first instr_valid 2 cycles after first SETUP.
2. instr_ready=0, DEPTH=4 -> exactly 4 transfers (addr 0-3), then psel=0 and IDLE. One pop -> exactly one new transfer at addr 4.
3. pready low 3 cycles on addr 2 -> ACCESS held 4 cycles with paddr=2 stable; data still ordered. pready low 15 cycles -> fetch_err pulse, halted=1, psel=0; previously buffered words still pop.
4. pslverr=1 at addr 5 -> no push of addr 5, fetch_err 1 cycle, halted=1. redirect_pc=0x20 -> halted=0, next paddr=0x20.
5. redirect_pc=0x40 asserted mid-ACCESS of addr 7 with 2 words buffered -> instr_valid=0 next cycle; addr-7 data is never delivered; next SETUP paddr=0x40; a simultaneous pop is ignored.
6. Redirect to 0xFFFE -> consumer sees pc 0xFFFE, 0xFFFF, 0x0000. Reset asserted mid-ACCESS -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/apb_fetch_master_if.sv
// APB3 bus bundle between the instruction-fetch master and the instruction memory.
interface apb_fetch_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_fetch_master.sv
// APB3 instruction-fetch master: prefetches sequential words into a show-ahead
// buffer, supports PC redirect with flush, slave-error halt and wait-state timeout.
module apb_fetch_master #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                TIMEOUT  = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              fetch_err,
    output logic              halted,
    apb_fetch_master_if.master apb
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HALT} state_t;

    state_t            state;
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [ADDR_W-1:0] buf_pc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic [ADDR_W-1:0] fetch_pc, pc_next;
    logic [TMR_W-1:0]  timer;
    logic              discard;
    logic              push, pop;

    assign instr_valid = (count != '0);
    assign instr_data  = buf_data[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];
    assign apb.pwrite  = 1'b0;
    assign apb.pwdata  = '0;

    // Redirect overrides both a completing push and a consumer pop.
    always_comb begin
        push       = (state == ACCESS) && apb.pready && !apb.pslverr && !discard && !redirect_valid;
        pop        = instr_valid && instr_ready && !redirect_valid;
        count_next = redirect_valid ? '0 : count + CNT_W'(push) - CNT_W'(pop);
        pc_next    = redirect_valid ? redirect_pc : (push ? fetch_pc + ADDR_W'(1) : fetch_pc);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.paddr   <= RESET_PC;
            fetch_err   <= 1'b0;
            halted      <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fetch_pc    <= RESET_PC;
            timer       <= '0;
            discard     <= 1'b0;
        end else begin
            fetch_err <= 1'b0;
            count     <= count_next;
            fetch_pc  <= pc_next;
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                halted <= 1'b0;
            end else begin
                if (push) begin
                    buf_data[wr_ptr] <= apb.prdata;
                    buf_pc[wr_ptr]   <= fetch_pc;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (!redirect_valid && count < CNT_W'(DEPTH)) begin
                        state     <= SETUP;
                        apb.psel  <= 1'b1;
                        apb.paddr <= fetch_pc;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    apb.penable <= 1'b1;
                    if (redirect_valid)
                        discard <= 1'b1;
                end
                ACCESS: begin
                    if (apb.pready) begin
                        timer       <= '0;
                        discard     <= 1'b0;
                        apb.penable <= 1'b0;
                        if (apb.pslverr && !discard && !redirect_valid) begin
                            fetch_err <= 1'b1;
                            halted    <= 1'b1;
                            apb.psel  <= 1'b0;
                            state     <= HALT;
                        end else if (count_next < CNT_W'(DEPTH)) begin
                            state     <= SETUP;
                            apb.paddr <= pc_next;
                        end else begin
                            state    <= IDLE;
                            apb.psel <= 1'b0;
                        end
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        // A timeout on a transfer already marked for discard is silent.
                        timer       <= '0;
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        if (discard || redirect_valid) begin
                            discard <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            fetch_err <= 1'b1;
                            halted    <= 1'b1;
                            state     <= HALT;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                        if (redirect_valid)
                            discard <= 1'b1;
                    end
                end
                HALT: begin
                    if (redirect_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_fetch_master.sv
// Self-checking bench for apb_fetch_master: APB memory model with stall/error
// injection, scoreboard of expected {pc, data} fetched words.
module tb_apb_fetch_master;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          instr_ready = 1'b0;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          fetch_err;
    logic          halted;

    apb_fetch_master_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

    apb_fetch_master #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .TIMEOUT(15), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_data(instr_data),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .fetch_err(fetch_err),
        .halted(halted),
        .apb(apb)
    );

    always #5 clk = ~clk;

    // Memory model: mem[a] = a + 0x100, optional wait states / error at one address.
    logic [AW-1:0] stall_addr = 16'hDEAD;
    logic [AW-1:0] err_addr   = 16'hBEEF;
    int unsigned   stall_len  = 0;
    logic          err_en     = 1'b0;
    int unsigned   wait_left  = 0;

    always @(posedge clk) begin
        if (apb.psel && !apb.penable)
            wait_left <= (apb.paddr == stall_addr) ? stall_len : 0;
        else if (apb.psel && apb.penable && wait_left != 0)
            wait_left <= wait_left - 1;
    end

    assign apb.pready  = (wait_left == 0);
    assign apb.prdata  = apb.paddr + 16'h0100;
    assign apb.pslverr = err_en && (apb.paddr == err_addr);

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] exp_pc = '0;
    bit            tb_disc = 0;
    int            setup_cnt, err_cnt, err_run, err_max, acc_len, last_acc_len;
    int            stall_seen_len, unstable, pop_cnt;
    logic [AW-1:0] last_acc_addr, setup_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus/consumer monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            exp_pc = '0; tb_disc = 0;
            setup_cnt = 0; err_cnt = 0; err_run = 0; err_max = 0;
            acc_len = 0; last_acc_len = 0; last_acc_addr = '0;
            stall_seen_len = 0; unstable = 0; pop_cnt = 0;
        end else begin
            if (instr_valid && instr_ready && !redirect_valid) begin
                check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("sb_pc", instr_pc, exp_q[0].pc);
                    check("sb_data", instr_data, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                pop_cnt++;
            end
            if (fetch_err) err_run++;
            else if (err_run != 0) begin
                if (err_run > err_max) err_max = err_run;
                err_cnt++;
                err_run = 0;
            end
            if (apb.psel && !apb.penable) begin
                setup_cnt++;
                setup_addr = apb.paddr;
                if (redirect_valid) tb_disc = 1;
            end else if (apb.psel && apb.penable) begin
                acc_len++;
                if (apb.paddr !== setup_addr) unstable++;
                if (apb.pready) begin
                    last_acc_len  = acc_len;
                    last_acc_addr = apb.paddr;
                    if (apb.paddr == stall_addr) stall_seen_len = acc_len;
                    acc_len = 0;
                    if (!tb_disc && !redirect_valid && !apb.pslverr) begin
                        check("fetch_addr", apb.paddr, exp_pc);
                        exp_q.push_back('{pc: exp_pc, data: exp_pc + 16'h0100});
                        exp_pc++;
                    end
                    tb_disc = 0;
                end else if (redirect_valid) begin
                    tb_disc = 1;
                end
            end else if (acc_len != 0) begin
                last_acc_len  = acc_len;
                last_acc_addr = apb.paddr;
                acc_len = 0;
                tb_disc = 0;
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_pc = redirect_pc;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_setup(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (apb.psel && !apb.penable) break;
        end
        check(tag, {apb.psel, apb.penable}, 2'b10);
    endtask

    task automatic do_redirect(input logic [AW-1:0] pc);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gap;
        int base;
        instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_psel", apb.psel, 0);
        check("rst_penable", apb.penable, 0);
        check("rst_paddr", apb.paddr, 16'h0000);
        check("rst_pwrite", apb.pwrite, 0);
        check("rst_pwdata", apb.pwdata, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_fetch_err", fetch_err, 0);

        // Zero-wait streaming
        @(posedge clk); #1 reset = 1'b1;
        wait_setup("t1_setup");
        check("t1_paddr0", apb.paddr, 16'h0000);
        @(negedge clk);
        check("t1_access", {apb.psel, apb.penable}, 2'b11);
        check("t1_valid_n1", instr_valid, 0);
        @(negedge clk);
        check("t1_valid_n2", instr_valid, 1);
        check("t1_pc0", instr_pc, 16'h0000);
        gap = 0;
        repeat (12) begin
            @(negedge clk);
            if (!apb.psel) gap++;
        end
        check("t1_psel_cont", gap, 0);
        check("t1_pops", 32'(pop_cnt >= 5), 1);

        // Full buffer with stalled consumer
        instr_ready = 1'b0;
        do_reset();
        cyc(40);
        @(negedge clk);
        check("t2_setups", setup_cnt, 4);
        check("t2_last_addr", last_acc_addr, 16'h0003);
        check("t2_psel_idle", apb.psel, 0);
        check("t2_valid", instr_valid, 1);
        check("t2_head_pc", instr_pc, 16'h0000);
        @(posedge clk); #1 instr_ready = 1'b1;
        @(posedge clk); #1 instr_ready = 1'b0;
        cyc(20);
        @(negedge clk);
        check("t2_setups_after_pop", setup_cnt, 5);
        check("t2_refill_addr", last_acc_addr, 16'h0004);
        check("t2_pop_cnt", pop_cnt, 1);
        check("t2_psel_idle2", apb.psel, 0);

        // Wait states on addr 2
        instr_ready = 1'b1;
        stall_addr = 16'h0002;
        stall_len  = 3;
        do_reset();
        cyc(30);
        @(negedge clk);
        check("t3_access_len", stall_seen_len, 4);
        check("t3_paddr_stable", unstable, 0);
        check("t3_pops", 32'(pop_cnt >= 8), 1);

        // Timeout on addr 2 with two words buffered
        instr_ready = 1'b0;
        stall_len   = 20;
        do_reset();
        cyc(40);
        @(negedge clk);
        check("t3_err_cnt", err_cnt, 1);
        check("t3_err_width", err_max, 1);
        check("t3_halted", halted, 1);
        check("t3_psel_low", apb.psel, 0);
        check("t3_timeout_len", last_acc_len, 15);
        check("t3_timeout_addr", last_acc_addr, 16'h0002);
        check("t3_setups", setup_cnt, 3);
        check("t3_head_pc", instr_pc, 16'h0000);
        @(posedge clk); #1 instr_ready = 1'b1;
        cyc(6);
        @(negedge clk);
        check("t3_drain_pops", pop_cnt, 2);
        check("t3_drained", instr_valid, 0);
        check("t3_still_halted", halted, 1);
        check("t3_no_fetch_halt", setup_cnt, 3);

        // Slave error at addr 5, then redirect out of HALT
        stall_addr = 16'hDEAD;
        err_addr   = 16'h0005;
        err_en     = 1'b1;
        do_reset();
        cyc(30);
        @(negedge clk);
        check("t4_halted", halted, 1);
        check("t4_err_cnt", err_cnt, 1);
        check("t4_err_width", err_max, 1);
        check("t4_psel_low", apb.psel, 0);
        check("t4_setups", setup_cnt, 6);
        check("t4_pops", pop_cnt, 5);
        do_redirect(16'h0020);
        @(negedge clk);
        check("t4_unhalted", halted, 0);
        wait_setup("t4_setup");
        check("t4_paddr", apb.paddr, 16'h0020);
        cyc(10);
        err_en = 1'b0;

        // Redirect mid-ACCESS of addr 7 with two words buffered
        stall_addr = 16'h0007;
        stall_len  = 8;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (apb.psel && !apb.penable && apb.paddr == 16'h0005) break;
        end
        check("t5_setup5", apb.paddr, 16'h0005);
        @(posedge clk); #1 instr_ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (apb.psel && apb.penable && apb.paddr == 16'h0007) break;
        end
        check("t5_access7", {apb.psel, apb.penable, apb.paddr}, {2'b11, 16'h0007});
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        instr_ready    = 1'b1;
        @(negedge clk);
        check("t5_buffered", instr_valid, 1);
        check("t5_head_pc", instr_pc, 16'h0005);
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_flushed", instr_valid, 0);
        wait_setup("t5_setup");
        check("t5_paddr", apb.paddr, 16'h0040);
        check("t5_prev_addr", last_acc_addr, 16'h0007);
        check("t5_prev_len", last_acc_len, 9);
        cyc(10);

        // Address wrap
        stall_addr = 16'hDEAD;
        do_redirect(16'hFFFE);
        base = pop_cnt;
        cyc(20);
        @(negedge clk);
        check("t6_wrap_pops", 32'(pop_cnt - base >= 4), 1);

        // Reset during ACCESS
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (apb.psel && apb.penable) break;
        end
        check("t6_in_access", {apb.psel, apb.penable}, 2'b11);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_psel", apb.psel, 0);
        check("t6_rst_penable", apb.penable, 0);
        check("t6_rst_paddr", apb.paddr, 16'h0000);
        check("t6_rst_valid", instr_valid, 0);
        check("t6_rst_halted", halted, 0);
        check("t6_rst_err", fetch_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
